// File: rtl/state_seq_pkg.sv
//==============================================================================
// Module : state_seq_pkg
// Brief  : Shared definitions for the 3-bit state sequence generator/monitor.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package state_seq_pkg;

    localparam logic [2:0] ST_RESET = 3'b111;
    localparam logic [2:0] ST_ENTRY = 3'b000;

    typedef enum logic [0:0] {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } mon_state_e;

    // M=1 rotation: 110>100>101>001>011>010>110, entered via 111>000>110
    function automatic logic [2:0] next_m1(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'b110:  n = 3'b100;
            3'b100:  n = 3'b101;
            3'b101:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b111:  n = ST_ENTRY;
            default: n = 3'b110;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] next_m0(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'b110:  n = 3'b010;
            3'b010:  n = 3'b011;
            3'b011:  n = 3'b001;
            3'b001:  n = 3'b101;
            3'b101:  n = 3'b100;
            3'b100:  n = 3'b110;
            3'b111:  n = ST_ENTRY;
            default: n = 3'b110;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/state_next_lut.sv
//==============================================================================
// Module : state_next_lut
// Brief  : Successor lookup for both rotation directions plus ambiguity flag.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module state_next_lut
    import state_seq_pkg::*;
(
    input  logic [2:0] i_prev,
    output logic [2:0] o_n1,
    output logic [2:0] o_n0,
    output logic       o_amb
);

    assign o_n1  = next_m1(i_prev);
    assign o_n0  = next_m0(i_prev);
    assign o_amb = (o_n1 == o_n0);

endmodule

`default_nettype wire

// File: rtl/state_decode_monitor.sv
//==============================================================================
// Module : state_decode_monitor
// Brief  : Recovers generator rotation direction from observed bus transitions,
//          flags illegal steps and reversals. Optional stall detector enabled
//          by defining STATE_DECODE_TIMEOUT_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module state_decode_monitor
    import state_seq_pkg::*;
#(
    parameter int LOCK_LEN    = 3,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             CR_n,
    input  logic [2:0]       data,
    output logic             mode,
    output logic             locked,
    output logic             err,
    output logic             mode_chg,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stall
);

    localparam int                c_run_w    = $clog2(LOCK_LEN + 1);
    localparam logic [c_run_w-1:0] c_lock_len = c_run_w'(LOCK_LEN);

    logic [2:0]         r_last;
    mon_state_e         r_state, w_state_nxt;
    logic [c_run_w-1:0] r_run,   w_run_nxt;
    logic               r_cand,  w_cand_nxt;
    logic               r_mode,  w_mode_nxt;
    logic               r_err,   w_err_nxt;
    logic               r_chg,   w_chg_nxt;
    logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;

    logic [2:0] w_n1, w_n0;
    logic       w_amb;
    logic       w_trans;

    state_next_lut u_lut (
        .i_prev (r_last),
        .o_n1   (w_n1),
        .o_n0   (w_n0),
        .o_amb  (w_amb)
    );

    assign w_trans = (data != r_last);

    always_ff @(posedge clk or negedge CR_n) begin
        if (!CR_n) begin
            r_last    <= ST_RESET;
            r_state   <= ACQ;
            r_run     <= '0;
            r_cand    <= 1'b0;
            r_mode    <= 1'b0;
            r_err     <= 1'b0;
            r_chg     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_last    <= data;
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_cand    <= w_cand_nxt;
            r_mode    <= w_mode_nxt;
            r_err     <= w_err_nxt;
            r_chg     <= w_chg_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_cand_nxt    = r_cand;
        w_mode_nxt    = r_mode;
        w_err_nxt     = 1'b0;
        w_chg_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;

        if (w_trans) begin
            if (data == ST_RESET) begin
                w_state_nxt = ACQ;
                w_run_nxt   = '0;
            end else if (w_amb && (data == w_n1)) begin
                // entry path is common to both directions: carries no mode info
            end else if (r_state == ACQ && data == (r_cand ? w_n1 : w_n0)) begin
                if (r_run < c_lock_len) begin
                    w_run_nxt = r_run + 1'b1;
                end
                if (w_run_nxt == c_lock_len) begin
                    w_state_nxt = LOCKED;
                    w_mode_nxt  = r_cand;
                end
            end else if (r_state == ACQ && data == (r_cand ? w_n0 : w_n1)) begin
                w_cand_nxt = ~r_cand;
                w_run_nxt  = c_run_w'(1);
            end else if (r_state == LOCKED && data == (r_mode ? w_n1 : w_n0)) begin
                w_state_nxt = LOCKED;
            end else if (r_state == LOCKED && data == (r_mode ? w_n0 : w_n1)) begin
                w_chg_nxt   = 1'b1;
                w_state_nxt = ACQ;
                w_cand_nxt  = ~r_mode;
                w_run_nxt   = c_run_w'(1);
            end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ACQ;
                w_run_nxt   = '0;
                if (r_err_cnt != {CNT_W{1'b1}}) begin
                    w_err_cnt_nxt = r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign mode     = r_mode;
    assign locked   = (r_state == LOCKED);
    assign err      = r_err;
    assign mode_chg = r_chg;
    assign err_cnt  = r_err_cnt;

`ifdef STATE_DECODE_TIMEOUT_EN
    localparam int                 c_idle_w   = $clog2(TIMEOUT_CYC);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT_CYC - 1);

    logic [c_idle_w-1:0] r_idle_cnt;
    logic                r_stall;

    // counter saturates at TIMEOUT_CYC-1, so equality stands in for >=
    always_ff @(posedge clk or negedge CR_n) begin
        if (!CR_n) begin
            r_idle_cnt <= '0;
            r_stall    <= 1'b0;
        end else if (w_trans) begin
            r_idle_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            if (r_idle_cnt != c_idle_max) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            r_stall <= (r_idle_cnt == c_idle_max);
        end
    end

    assign stall = r_stall;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign stall            = 1'b0;
`endif

endmodule

`default_nettype wire
